// File: rtl/array_stream_reader.sv
// Streams `count` words read from an array port starting at `base`,
// with credit-limited requests into a 2-entry output FIFO.
module array_stream_reader #(
    parameter int intN  = 8,
    parameter int addrN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [addrN-1:0] in_base,
    input  logic [addrN-1:0] in_count,
    output logic             arr_valid,
    input  logic             arr_ready,
    output logic [addrN-1:0] arr_addr,
    output logic             arr_we,
    output logic [intN-1:0]  arr_di,
    input  logic [intN-1:0]  arr_do,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [intN-1:0]  out_data,
    output logic             out_last,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic [addrN-1:0] ptr_q;
    logic [addrN-1:0] rem_q;
    logic             infl_q;
    logic             infl_last_q;
    logic [1:0]       cnt_q;
    logic [intN-1:0]  head_q;
    logic [intN-1:0]  tail_q;
    logic             head_last_q;
    logic             tail_last_q;
    logic             done_q;

    logic             credit;
    logic             issue;
    logic             accept;
    logic             push;
    logic             pop;
    logic             rem_one;

    // Occupancy plus the one word that may still be on its way back.
    assign credit    = ({1'b0, cnt_q} + {2'b00, infl_q}) < 3'd2;
    assign arr_valid = (state_q == ISSUE) && credit;
    assign issue     = arr_valid && arr_ready;
    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = infl_q;
    assign rem_one   = (rem_q == addrN'(1));

    assign arr_addr  = ptr_q;
    assign arr_we    = 1'b0;
    assign arr_di    = '0;
    assign out_data  = head_q;
    assign out_last  = head_last_q;
    assign done      = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            infl_q      <= issue;
            infl_last_q <= issue && rem_one;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (in_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            ptr_q   <= in_base;
                            rem_q   <= in_count;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        ptr_q <= ptr_q + addrN'(1);
                        rem_q <= rem_q - addrN'(1);
                        if (rem_one) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head_last_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Head register is the visible output; tail only fills when head is busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
            head_last_q <= 1'b0;
            tail_last_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_q      <= arr_do;
                        head_last_q <= infl_last_q;
                    end else begin
                        tail_q      <= arr_do;
                        tail_last_q <= infl_last_q;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q      <= tail_q;
                    head_last_q <= (cnt_q == 2'd2) && tail_last_q;
                    cnt_q       <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q      <= arr_do;
                        head_last_q <= infl_last_q;
                    end else begin
                        head_q      <= tail_q;
                        head_last_q <= tail_last_q;
                        tail_q      <= arr_do;
                        tail_last_q <= infl_last_q;
                    end
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_stream_reader.sv
// Bench for array_stream_reader: directed scenarios plus random commands,
// checked against a flat array model of the expected address/data stream.
module tb_array_stream_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_base = 8'd0;
    logic [7:0] in_count = 8'd0;
    logic       arr_valid;
    logic       arr_ready = 1'b0;
    logic [7:0] arr_addr;
    logic       arr_we;
    logic [7:0] arr_di;
    logic [7:0] arr_do = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       done;

    logic [7:0] mem [256];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    array_stream_reader #(.intN(8), .addrN(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_base(in_base), .in_count(in_count),
        .arr_valid(arr_valid), .arr_ready(arr_ready),
        .arr_addr(arr_addr), .arr_we(arr_we),
        .arr_di(arr_di), .arr_do(arr_do),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .done(done)
    );

    // Array model: data one cycle after acceptance, garbage otherwise.
    always @(posedge clk) begin
        if (arr_valid && arr_ready) arr_do <= mem[arr_addr];
        else arr_do <= 8'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [7:0] base, input logic [7:0] cnt,
                           input int ar_mode, input int or_mode,
                           input int or_hold, input string name);
        logic [7:0] req_q[$];
        logic [7:0] dat_q[$];
        logic       lst_q[$];
        int done_n = 0, done_cyc = -1, first_req = -1, first_ov = -1;
        int last_pop = -1, ready_bad = 0, addr_bad = 0, out_bad = 0;
        int over = 0, pre_pop = 0;
        logic pv_stall = 1'b0, po_stall = 1'b0, p_last = 1'b0;
        logic [7:0] p_addr = 8'd0, p_data = 8'd0;
        logic [7:0] a;
        bit fin = 0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            in_valid = (cyc == 0);
            in_base  = base;
            in_count = cnt;
            case (ar_mode)
                0: arr_ready = 1'b1;
                1: arr_ready = (cyc % 2) == 1;
                default: arr_ready = 1'($urandom_range(0, 1));
            endcase
            if (cyc < or_hold) out_ready = 1'b0;
            else if (or_mode == 0) out_ready = 1'b1;
            else out_ready = 1'($urandom_range(0, 1));
            #1;
            if (cyc == 0) check({name, " in_ready_at_accept"}, in_ready, 1);
            if (pv_stall && (!arr_valid || arr_addr !== p_addr)) addr_bad++;
            if (po_stall && (!out_valid || out_data !== p_data ||
                             out_last !== p_last)) out_bad++;
            if (arr_valid && arr_ready) begin
                if (first_req < 0) first_req = cyc;
                req_q.push_back(arr_addr);
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                dat_q.push_back(out_data);
                lst_q.push_back(out_last);
                last_pop = cyc;
            end
            if (dat_q.size() == 0) pre_pop = req_q.size();
            if (req_q.size() - dat_q.size() > 2) over++;
            pv_stall = arr_valid && !arr_ready;
            p_addr   = arr_addr;
            po_stall = out_valid && !out_ready;
            p_data   = out_data;
            p_last   = out_last;
            if (done) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check({name, " in_ready_at_done"}, in_ready, 1);
                end
            end
            if (cyc > 0 && done_cyc < 0 && in_ready) ready_bad++;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) fin = 1;
        end
        in_valid = 1'b0;
        check({name, " completed"}, done_cyc >= 0, 1);
        check({name, " done_pulses"}, done_n, 1);
        check({name, " req_count"}, req_q.size(), cnt);
        check({name, " word_count"}, dat_q.size(), cnt);
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + 8'(i);
            if (i < req_q.size()) check({name, " addr"}, req_q[i], a);
            if (i < dat_q.size()) begin
                check({name, " data"}, dat_q[i], mem[a]);
                check({name, " last"}, lst_q[i], i == int'(cnt) - 1);
            end
        end
        check({name, " in_ready_low_busy"}, ready_bad, 0);
        check({name, " addr_stable"}, addr_bad, 0);
        check({name, " out_stable"}, out_bad, 0);
        check({name, " no_overflow"}, over, 0);
        if (cnt != 8'd0) begin
            check({name, " done_after_last_pop"}, done_cyc, last_pop + 1);
            check({name, " reqs_before_pop_le2"}, pre_pop <= 2, 1);
            if (ar_mode == 0 && or_mode == 0 && or_hold == 0) begin
                check({name, " first_req_cycle"}, first_req, 1);
                check({name, " first_out_cycle"}, first_ov, 3);
            end
        end else begin
            check({name, " zero_done_cycle"}, done_cyc, 1);
            check({name, " zero_no_out"}, first_ov, -1);
            check({name, " zero_no_req"}, first_req, -1);
        end
    endtask

    initial begin
        int nreq;
        int k;
        logic seen_done, seen_ov;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[1] = 8'd10; mem[2] = 8'd20; mem[3] = 8'd30;
        mem[8'hFE] = 8'd1; mem[8'hFF] = 8'd2; mem[0] = 8'd3;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst in_ready", in_ready, 1);
        check("rst arr_valid", arr_valid, 0);
        check("rst arr_addr", arr_addr, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_last", out_last, 0);
        check("rst out_data", out_data, 0);
        check("rst done", done, 0);
        check("rst arr_we", arr_we, 0);
        check("rst arr_di", arr_di, 0);

        run_cmd(8'd1, 8'd3, 0, 0, 0, "basic");
        run_cmd(8'd1, 8'd3, 0, 0, 10, "backpressure");
        run_cmd(8'hFE, 8'd3, 0, 0, 0, "wrap");
        run_cmd(8'd5, 8'd0, 0, 0, 0, "zero");
        run_cmd(8'd0, 8'd4, 1, 0, 0, "stall");

        // Reset one cycle after the second request of a 4-word command.
        nreq = 0;
        k = 0;
        @(negedge clk);
        in_valid = 1'b1; in_base = 8'd0; in_count = 8'd4;
        arr_ready = 1'b1; out_ready = 1'b1;
        while (nreq < 2 && k < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (arr_valid && arr_ready) nreq++;
            k++;
        end
        check("midrst two_reqs", nreq, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst in_ready", in_ready, 1);
        check("midrst arr_valid", arr_valid, 0);
        check("midrst arr_addr", arr_addr, 0);
        check("midrst out_valid", out_valid, 0);
        check("midrst out_last", out_last, 0);
        check("midrst out_data", out_data, 0);
        check("midrst done", done, 0);
        seen_done = 1'b0;
        seen_ov = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            seen_done = seen_done | done;
            seen_ov = seen_ov | out_valid | arr_valid;
        end
        check("midrst no_done", seen_done, 0);
        check("midrst quiet", seen_ov, 0);
        run_cmd(8'd1, 8'd1, 0, 0, 0, "after_rst");

        for (int r = 0; r < 10; r++) begin
            run_cmd(8'($urandom), 8'($urandom_range(0, 12)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)), "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
